// File: rtl/ste_avg_ctrl.sv
// Sequencing controller for the IIR averaging filter: clears and enables the filter,
// blanks out settling samples after a restart, and decimates filtered data to the display.
module ste_avg_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned SETTLE_N = 8,
    parameter int unsigned DISP_DIV = 4,
    parameter int unsigned FILT_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid_i,
    input  logic              range_chg_i,
    input  logic              avg_req_i,
    input  logic              hold_i,
    input  logic [DATA_W-1:0] avg_din_i,
    output logic              avg_clr_o,
    output logic              avg_en_o,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              disp_update_o,
    output logic              settled_o,
    output logic [1:0]        state_o
);

    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    if ((CNT_W < 1) || (CNT_W > 31) ||
        (SETTLE_N < 1) || (SETTLE_N > CNT_MAX) ||
        (DISP_DIV < 1) || (DISP_DIV > CNT_MAX) ||
        (FILT_LAT < 1) || (FILT_LAT > 4)) begin : g_param_err
        $error("ste_avg_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        CLEAR  = 2'b00,
        SETTLE = 2'b01,
        RUN    = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                avg_req_q;
    logic [CNT_W-1:0]    settle_cnt;
    logic [CNT_W-1:0]    dec_cnt;
    logic [FILT_LAT-1:0] pipe;

    logic restart_c;
    logic settle_last_c;
    logic dec_last_c;
    logic token_in_c;
    logic token_out_c;

    assign restart_c     = range_chg_i | (avg_req_i ^ avg_req_q);
    assign settle_last_c = (settle_cnt == CNT_W'(SETTLE_N - 1));
    assign dec_last_c    = (dec_cnt == CNT_W'(DISP_DIV - 1));
    assign token_in_c    = (state == RUN) && sample_valid_i && !restart_c && dec_last_c;
    assign token_out_c   = pipe[FILT_LAT-1] && (state == RUN) && !restart_c;
    assign state_o       = state;

    // Next-state logic; CLEAR is held until its clear pulse has been presented once.
    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   state_nx = avg_clr_o ? SETTLE : CLEAR;
            SETTLE:  if (sample_valid_i && settle_last_c) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = CLEAR;
        endcase
        if (restart_c) state_nx = CLEAR;
    end

    // State, counters, capture pipe and registered outputs aligned with the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CLEAR;
            avg_req_q     <= 1'b0;
            settle_cnt    <= '0;
            dec_cnt       <= '0;
            pipe          <= '0;
            avg_clr_o     <= 1'b0;
            avg_en_o      <= 1'b0;
            settled_o     <= 1'b0;
            disp_update_o <= 1'b0;
            disp_data_o   <= '0;
        end else begin
            state     <= state_nx;
            avg_req_q <= avg_req_i;
            avg_clr_o <= (state_nx == CLEAR);
            avg_en_o  <= (state_nx != CLEAR) && avg_req_q;
            settled_o <= (state_nx == RUN);

            pipe <= restart_c ? '0 : FILT_LAT'({pipe, token_in_c});

            disp_update_o <= token_out_c && !hold_i;
            if (token_out_c && !hold_i) disp_data_o <= avg_din_i;

            if (restart_c || ((state != SETTLE) && (state != RUN))) begin
                settle_cnt <= '0;
                dec_cnt    <= '0;
            end else if ((state == SETTLE) && sample_valid_i) begin
                settle_cnt <= settle_last_c ? '0 : settle_cnt + CNT_W'(1);
            end else if ((state == RUN) && sample_valid_i) begin
                dec_cnt <= dec_last_c ? '0 : dec_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ste_avg_ctrl.sv
// Directed bench for ste_avg_ctrl with a scoreboard of expected display updates.
module tb_ste_avg_ctrl;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SETTLE_N = 8;
    localparam int unsigned DISP_DIV = 4;
    localparam int unsigned FILT_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sample_valid_i;
    logic              range_chg_i;
    logic              avg_req_i;
    logic              hold_i;
    logic [DATA_W-1:0] avg_din_i;
    logic              avg_clr_o;
    logic              avg_en_o;
    logic [DATA_W-1:0] disp_data_o;
    logic              disp_update_o;
    logic              settled_o;
    logic [1:0]        state_o;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_upd   = 0;
    int          cyc     = 0;
    logic [15:0] last_exp = '0;

    ste_avg_ctrl #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .SETTLE_N(SETTLE_N),
        .DISP_DIV(DISP_DIV), .FILT_LAT(FILT_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid_i(sample_valid_i),
        .range_chg_i(range_chg_i), .avg_req_i(avg_req_i), .hold_i(hold_i),
        .avg_din_i(avg_din_i), .avg_clr_o(avg_clr_o), .avg_en_o(avg_en_o),
        .disp_data_o(disp_data_o), .disp_update_o(disp_update_o),
        .settled_o(settled_o), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] din_at(input int c);
        return 16'(c * 37 + 11);
    endfunction

    // Filter output ramps with the cycle index so every capture has a distinct value.
    initial begin
        avg_din_i = din_at(0);
        forever begin
            @(posedge clk);
            #1;
            avg_din_i = din_at(cyc);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every display update must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && disp_update_o) begin
            n_upd++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_update: got update data %0d at cycle %0d, required none",
                         disp_data_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("upd_cycle", cyc, mon_e.cyc);
                check("upd_data", int'(disp_data_o), int'(mon_e.data));
            end
        end
    end

    task automatic tick(input logic v, input logic rc, input logic ex);
        sample_valid_i = v;
        range_chg_i    = rc;
        if (ex) begin
            last_exp = din_at(cyc + int'(FILT_LAT));
            sb.push_back('{cyc: cyc + int'(FILT_LAT) + 1, data: last_exp});
        end
        @(posedge clk);
        #1;
        sample_valid_i = 1'b0;
        range_chg_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic vgap(input logic ex, input int gap);
        tick(1'b1, 1'b0, ex);
        idle(gap);
    endtask

    task automatic settle_run(input int gap);
        for (int i = 1; i <= int'(SETTLE_N); i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (i == int'(SETTLE_N) - 1) begin
                check("settle_not_done", state_o, 1);
                check("settled_low", settled_o, 0);
            end
            if (i == int'(SETTLE_N)) begin
                check("run_state", state_o, 2);
                check("settled_rise", settled_o, 1);
            end
            idle(gap);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state_o, 0);
        check({tag, "_clr"}, avg_clr_o, 0);
        check({tag, "_en"}, avg_en_o, 0);
        check({tag, "_settled"}, settled_o, 0);
        check({tag, "_data"}, int'(disp_data_o), 0);
        check({tag, "_upd"}, disp_update_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          u0;
        logic [15:0] held;
        rst_n          = 1'b0;
        sample_valid_i = 1'b0;
        range_chg_i    = 1'b0;
        avg_req_i      = 1'b1;
        hold_i         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // 1: release reset, single clear pulse, settle at 8th valid, first update
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("t1_clr_pulse", avg_clr_o, 1);
        check("t1_clear_state", state_o, 0);
        @(posedge clk); #1;
        check("t1_clr_end", avg_clr_o, 0);
        check("t1_settle_state", state_o, 1);
        check("t1_en", avg_en_o, 1);
        settle_run(9);
        for (int i = 1; i <= 4; i++) vgap(i == 4, 9);
        check("t1_upd_count", n_upd, 1);

        // 2: ramping data, 20 valids give 5 updates
        u0 = n_upd;
        for (int i = 0; i < 20; i++) vgap((i % 4) == 3, 4);
        check("t2_upd_count", n_upd - u0, 5);

        // 3: range change (with a coincident valid) while a token is in flight
        for (int i = 1; i <= 3; i++) vgap(1'b0, 3);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("t3_clear_state", state_o, 0);
        check("t3_clr", avg_clr_o, 1);
        check("t3_settled_drop", settled_o, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("t3_settle_state", state_o, 1);
        check("t3_clr_end", avg_clr_o, 0);
        settle_run(3);
        check("t3_data_kept", int'(disp_data_o), int'(last_exp));

        // 4: averaging turned off in RUN
        avg_req_i = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        check("t4_clear_state", state_o, 0);
        check("t4_clr", avg_clr_o, 1);
        check("t4_en_off", avg_en_o, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("t4_settle_state", state_o, 1);
        check("t4_en_settle", avg_en_o, 0);
        settle_run(3);
        check("t4_en_run", avg_en_o, 0);
        u0 = n_upd;
        for (int i = 1; i <= 4; i++) vgap(i == 4, 4);
        check("t4_upd_count", n_upd - u0, 1);
        avg_req_i = 1'b1;
        idle(2);
        settle_run(3);
        check("t4_en_back", avg_en_o, 1);

        // 5: hold across 12 valids, then phase-preserving resume, then release in flight
        hold_i = 1'b1;
        held   = disp_data_o;
        u0     = n_upd;
        for (int i = 0; i < 12; i++) vgap(1'b0, 4);
        check("t5_hold_data", int'(disp_data_o), int'(held));
        check("t5_hold_no_upd", n_upd - u0, 0);
        hold_i = 1'b0;
        for (int i = 1; i <= 4; i++) vgap(i == 4, 4);
        for (int i = 1; i <= 3; i++) vgap(1'b0, 4);
        hold_i = 1'b1;
        tick(1'b1, 1'b0, 1'b1);
        hold_i = 1'b0;
        idle(5);
        check("t5_upd_count", n_upd - u0, 2);

        // 6: asynchronous reset mid-SETTLE
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) vgap(1'b0, 3);
        check("t6_in_settle", state_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_clr_pulse", avg_clr_o, 1);
        @(posedge clk); #1;
        check("t6_settle_state", state_o, 1);
        settle_run(3);
        for (int i = 1; i <= 4; i++) vgap(i == 4, 4);

        idle(10);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
